canny_threshold_encode: RTL and testbench



---
 rtl/canny_threshold_encode.sv | 128 ++++++++++++
 tb/tb_canny_threshold_encode.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/canny_threshold_encode.sv
// canny_threshold_encode: classifies NMS gradient magnitudes into 2-bit strong/weak/none codes
// Ports:
//   clk, rst_s                      pixel clock, synchronous active-low reset
//   pre_frame_vsync/href/clken      input frame, line and pixel valid
//   pre_mag                         gradient magnitude after NMS
//   thr_low, thr_high               weak/strong thresholds, latched at frame start
//   post_frame_vsync/href/clken     sync signals delayed 2 cycles
//   max_g                           2'b10 strong, 2'b01 weak, 2'b00 none
//   strong_cnt, weak_cnt            per-frame pixel counts of the last completed frame
//   stat_valid                      one-cycle pulse when the counts update
module canny_threshold_encode #(
    parameter int MAG_WIDTH   = 11,
    parameter int IMG_WIDTH   = 640,
    parameter int IMG_HEIGHT  = 480,
    parameter int CNT_WIDTH   = 20,
    parameter int BORDER_ZERO = 1
) (
    input  logic                 clk,
    input  logic                 rst_s,
    input  logic                 pre_frame_vsync,
    input  logic                 pre_frame_href,
    input  logic                 pre_frame_clken,
    input  logic [MAG_WIDTH-1:0] pre_mag,
    input  logic [MAG_WIDTH-1:0] thr_low,
    input  logic [MAG_WIDTH-1:0] thr_high,
    output logic                 post_frame_vsync,
    output logic                 post_frame_href,
    output logic                 post_frame_clken,
    output logic [1:0]           max_g,
    output logic [CNT_WIDTH-1:0] strong_cnt,
    output logic [CNT_WIDTH-1:0] weak_cnt,
    output logic                 stat_valid
);
    localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    logic                 r1_vsync, r1_href, r1_clken, r1_ok, r2_ok, r3_vsync, r_vs_ok;
    logic [MAG_WIDTH-1:0] r1_mag, r_thr_low, r_thr_high;
    logic [CW-1:0]        r_col_cnt, r1_col;
    logic [RW-1:0]        r_row_cnt, r1_row;
    logic [CNT_WIDTH-1:0] r_acc_s, r_acc_w;

    logic                 w_vs_rise, w_href_fall, w_border, w_vs2_rise, w_vs2_fall;
    logic [1:0]           w_code, w_max_g;
    logic [CNT_WIDTH-1:0] w_s_base, w_w_base, w_s_next, w_w_next;

    // r_vs_ok is set once vsync has been seen low after reset, so a reset in the
    // middle of a frame neither fakes a frame start nor reports the aborted frame.
    assign w_vs_rise   = pre_frame_vsync & ~r1_vsync & r_vs_ok;
    assign w_href_fall = r1_href & ~pre_frame_href;
    assign w_code      = (r1_mag >= r_thr_high) ? 2'b10 : (r1_mag >= r_thr_low) ? 2'b01 : 2'b00;
    assign w_border    = (BORDER_ZERO != 0) && (r1_col == '0 || r1_col == COL_LAST ||
                                                r1_row == '0 || r1_row == ROW_LAST);
    assign w_max_g     = (r1_clken && !w_border) ? w_code : 2'b00;

    // The accumulator update is folded into the snapshot so a pixel landing on
    // the vsync falling-edge cycle still counts towards its own frame.
    assign w_vs2_rise  = post_frame_vsync & ~r3_vsync;
    assign w_vs2_fall  = ~post_frame_vsync & r3_vsync;
    assign w_s_base    = w_vs2_rise ? '0 : r_acc_s;
    assign w_w_base    = w_vs2_rise ? '0 : r_acc_w;
    assign w_s_next    = (post_frame_clken && max_g == 2'b10 && ~&w_s_base) ? w_s_base + 1'b1 : w_s_base;
    assign w_w_next    = (post_frame_clken && max_g == 2'b01 && ~&w_w_base) ? w_w_base + 1'b1 : w_w_base;

    always_ff @(posedge clk) begin
        if (!rst_s) begin
            r1_vsync         <= 1'b0;
            r1_href          <= 1'b0;
            r1_clken         <= 1'b0;
            r1_mag           <= '0;
            r1_col           <= '0;
            r1_row           <= '0;
            r1_ok            <= 1'b0;
            r2_ok            <= 1'b0;
            r3_vsync         <= 1'b0;
            r_vs_ok          <= 1'b0;
            r_col_cnt        <= '0;
            r_row_cnt        <= '0;
            r_thr_low        <= '1;
            r_thr_high       <= '1;
            r_acc_s          <= '0;
            r_acc_w          <= '0;
            post_frame_vsync <= 1'b0;
            post_frame_href  <= 1'b0;
            post_frame_clken <= 1'b0;
            max_g            <= 2'b00;
            strong_cnt       <= '0;
            weak_cnt         <= '0;
            stat_valid       <= 1'b0;
        end else begin
            r1_vsync         <= pre_frame_vsync;
            r1_href          <= pre_frame_href;
            r1_clken         <= pre_frame_clken;
            r1_mag           <= pre_mag;
            r1_col           <= r_col_cnt;
            r1_row           <= r_row_cnt;
            r1_ok            <= r_vs_ok;
            r2_ok            <= r1_ok;
            r3_vsync         <= post_frame_vsync;
            r_vs_ok          <= r_vs_ok | ~pre_frame_vsync;
            if (!pre_frame_href)
                r_col_cnt <= '0;
            else if (pre_frame_clken && r_col_cnt != COL_LAST)
                r_col_cnt <= r_col_cnt + 1'b1;
            if (w_vs_rise)
                r_row_cnt <= '0;
            else if (w_href_fall && r_row_cnt != ROW_LAST)
                r_row_cnt <= r_row_cnt + 1'b1;
            if (w_vs_rise) begin
                r_thr_low  <= thr_low;
                r_thr_high <= thr_high;
            end
            post_frame_vsync <= r1_vsync;
            post_frame_href  <= r1_href;
            post_frame_clken <= r1_clken;
            max_g            <= w_max_g;
            r_acc_s          <= w_s_next;
            r_acc_w          <= w_w_next;
            stat_valid       <= w_vs2_fall & r2_ok;
            if (w_vs2_fall && r2_ok) begin
                strong_cnt <= w_s_next;
                weak_cnt   <= w_w_next;
            end
        end
    end
endmodule

// File: tb/tb_canny_threshold_encode.sv
// tb_canny_threshold_encode: directed frame vectors for canny_threshold_encode, border on and off
module tb_canny_threshold_encode;
    logic        clk = 1'b0;
    logic        rst_s = 1'b0;
    logic        vs = 1'b0, hs = 1'b0, ck = 1'b0;
    logic [10:0] mag = '0, tl = '0, th = '0;
    logic        pv0, ph0, pc0, sv0, pv1, ph1, pc1, sv1;
    logic [1:0]  mg0, mg1;
    logic [19:0] sc0, wc0, sc1, wc1;

    int checks = 0;
    int failures = 0;
    int np0 = 0, np1 = 0;

    typedef struct packed {
        logic       v, h, c;
        logic [1:0] e0, e1;
    } hist_t;

    typedef struct {
        logic [10:0]      tl, th;
        logic [3:0][10:0] mag;
        logic [3:0][1:0]  e;
        int               chg;
        logic [10:0]      th_new;
        bit               gap;
        int               s0, w0, s1, w1;
    } frame_t;

    hist_t  h1 = '0, h2 = '0;
    frame_t frames[6];

    always #5 clk = ~clk;

    canny_threshold_encode #(.IMG_WIDTH(4), .IMG_HEIGHT(3), .BORDER_ZERO(0)) u0 (
        .clk(clk), .rst_s(rst_s),
        .pre_frame_vsync(vs), .pre_frame_href(hs), .pre_frame_clken(ck), .pre_mag(mag),
        .thr_low(tl), .thr_high(th),
        .post_frame_vsync(pv0), .post_frame_href(ph0), .post_frame_clken(pc0),
        .max_g(mg0), .strong_cnt(sc0), .weak_cnt(wc0), .stat_valid(sv0)
    );

    canny_threshold_encode #(.IMG_WIDTH(4), .IMG_HEIGHT(3), .BORDER_ZERO(1)) u1 (
        .clk(clk), .rst_s(rst_s),
        .pre_frame_vsync(vs), .pre_frame_href(hs), .pre_frame_clken(ck), .pre_mag(mag),
        .thr_low(tl), .thr_high(th),
        .post_frame_vsync(pv1), .post_frame_href(ph1), .post_frame_clken(pc1),
        .max_g(mg1), .strong_cnt(sc1), .weak_cnt(wc1), .stat_valid(sv1)
    );

    task automatic chk(input string n, input int a, input int e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", n, a, e, $time);
        end
    endtask

    // Outputs seen at a negedge belong to the inputs applied two negedges earlier.
    task automatic step(input logic v, input logic h, input logic c, input logic [10:0] m,
                        input logic [1:0] e0, input logic [1:0] e1);
        @(negedge clk);
        chk("vsync0", int'(pv0), int'(h2.v));
        chk("href0", int'(ph0), int'(h2.h));
        chk("clken0", int'(pc0), int'(h2.c));
        chk("max_g0", int'(mg0), int'(h2.e0));
        chk("vsync1", int'(pv1), int'(h2.v));
        chk("href1", int'(ph1), int'(h2.h));
        chk("clken1", int'(pc1), int'(h2.c));
        chk("max_g1", int'(mg1), int'(h2.e1));
        if (sv0) np0++;
        if (sv1) np1++;
        h2 = h1;
        h1 = '{v: v, h: h, c: c, e0: e0, e1: e1};
        vs = v; hs = h; ck = c; mag = m;
    endtask

    task automatic zero_outputs(input string n);
        chk({n, "_post0"}, int'({pv0, ph0, pc0}), 0);
        chk({n, "_post1"}, int'({pv1, ph1, pc1}), 0);
        chk({n, "_max_g"}, int'({mg0, mg1}), 0);
        chk({n, "_cnt0"}, int'(sc0) + int'(wc0), 0);
        chk({n, "_cnt1"}, int'(sc1) + int'(wc1), 0);
        chk({n, "_stat"}, int'({sv0, sv1}), 0);
    endtask

    task automatic frame_end(input string n);
        repeat (6) step(1'b0, 1'b0, 1'b0, '0, 2'b00, 2'b00);
    endtask

    task automatic run_frame(input frame_t f, input string n);
        logic [1:0] code;
        np0 = 0; np1 = 0;
        tl = f.tl; th = f.th;
        step(1'b0, 1'b0, 1'b0, '0, 2'b00, 2'b00);
        step(1'b1, 1'b0, 1'b0, '0, 2'b00, 2'b00);
        step(1'b1, 1'b0, 1'b0, '0, 2'b00, 2'b00);
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (f.gap && c == 2) step(1'b1, 1'b1, 1'b0, '0, 2'b00, 2'b00);
                if (r * 4 + c == f.chg) th = f.th_new;
                code = f.e[c];
                step(1'b1, 1'b1, 1'b1, f.mag[c], code, (r == 1 && (c == 1 || c == 2)) ? code : 2'b00);
            end
            step(1'b1, 1'b0, 1'b0, '0, 2'b00, 2'b00);
            step(1'b1, 1'b0, 1'b0, '0, 2'b00, 2'b00);
        end
        frame_end(n);
        chk({n, "_strong0"}, int'(sc0), f.s0);
        chk({n, "_weak0"}, int'(wc0), f.w0);
        chk({n, "_strong1"}, int'(sc1), f.s1);
        chk({n, "_weak1"}, int'(wc1), f.w1);
        chk({n, "_pulses0"}, np0, 1);
        chk({n, "_pulses1"}, np1, 1);
    endtask

    initial begin
        frames[0] = '{11'd100, 11'd200, {11'd200, 11'd199, 11'd100, 11'd99}, {2'd2, 2'd1, 2'd1, 2'd0},
                      -1, 11'd0, 1'b0, 3, 6, 0, 2};
        frames[1] = '{11'd100, 11'd200, {11'd300, 11'd300, 11'd300, 11'd300}, {2'd2, 2'd2, 2'd2, 2'd2},
                      -1, 11'd0, 1'b0, 12, 0, 2, 0};
        frames[2] = '{11'd100, 11'd200, {11'd150, 11'd150, 11'd150, 11'd150}, {2'd1, 2'd1, 2'd1, 2'd1},
                      4, 11'd50, 1'b0, 0, 12, 0, 2};
        frames[3] = '{11'd100, 11'd50, {11'd60, 11'd60, 11'd60, 11'd60}, {2'd2, 2'd2, 2'd2, 2'd2},
                      -1, 11'd0, 1'b0, 12, 0, 2, 0};
        frames[4] = '{11'd300, 11'd200, {11'd350, 11'd250, 11'd350, 11'd250}, {2'd2, 2'd2, 2'd2, 2'd2},
                      -1, 11'd0, 1'b0, 12, 0, 2, 0};
        frames[5] = '{11'd100, 11'd200, {11'd200, 11'd199, 11'd100, 11'd99}, {2'd2, 2'd1, 2'd1, 2'd0},
                      -1, 11'd0, 1'b1, 3, 6, 0, 2};

        repeat (3) @(negedge clk);
        zero_outputs("reset");
        rst_s = 1'b1;

        for (int i = 0; i < 6; i++) run_frame(frames[i], $sformatf("frame%0d", i));

        np0 = 0; np1 = 0;
        tl = 11'd100; th = 11'd200;
        step(1'b1, 1'b0, 1'b0, '0, 2'b00, 2'b00);
        step(1'b1, 1'b0, 1'b0, '0, 2'b00, 2'b00);
        for (int c = 0; c < 4; c++) step(1'b1, 1'b1, 1'b1, 11'd150, 2'b01, 2'b00);
        step(1'b1, 1'b0, 1'b0, '0, 2'b00, 2'b00);
        @(negedge clk);
        rst_s = 1'b0;
        vs = 1'b1; hs = 1'b0; ck = 1'b0; mag = '0;
        @(negedge clk);
        zero_outputs("midrst");
        rst_s = 1'b1;
        h2 = '0;
        h1 = '{v: 1'b1, h: 1'b0, c: 1'b0, e0: 2'b00, e1: 2'b00};
        for (int r = 1; r < 3; r++) begin
            for (int c = 0; c < 4; c++) step(1'b1, 1'b1, 1'b1, 11'd150, 2'b00, 2'b00);
            step(1'b1, 1'b0, 1'b0, '0, 2'b00, 2'b00);
            step(1'b1, 1'b0, 1'b0, '0, 2'b00, 2'b00);
        end
        frame_end("aborted");
        chk("aborted_pulses0", np0, 0);
        chk("aborted_pulses1", np1, 0);
        chk("aborted_cnt0", int'(sc0) + int'(wc0), 0);

        run_frame(frames[0], "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
